tdc_meas_ctrl: RTL
==================

Name: tdc_meas_ctrl

Overview:
- Measurement sequencer for the TDC core (tapped delay line, 7-bit fine decode, 10-bit coarse counter).
- Arms the TDC, pairs the first two timestamps after arming as start/stop, and computes the interval in fine bins.
- Applies a stop timeout and presents the result on a valid/ready handshake toward readout.
- Sits between the TDC core's timestamp output and the readout/FIFO logic.

Parameters:
- COARSE_W, 10: coarse counter width; the coarse count wraps modulo 2^COARSE_W.
- FINE_W, 7: fine code width, in bins from the hit to the capturing clock edge.
- BINS_PER_CLK, 120: fine bins per clock period; must be ≤ 2^FINE_W.
- TIMEOUT_CYC, 1023: maximum number of cycles from start to stop.
- RES_W, COARSE_W+FINE_W: result width in bins.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  synchronous reset, active-low.
- iArm  in  1  single-cycle pulse; starts a measurement from IDLE.
- iAbort  in  1  forces a return to IDLE from any state; no result is produced.
- iTdcValid  in  1  TDC timestamp strobe, 1 cycle per hit.
- iTdcCoarse  in  COARSE_W  coarse count of the hit.
- iTdcFine  in  FINE_W  fine code of the hit.
- oArmed  out  1  high in ARMED.
- oBusy  out  1  high in any state except IDLE.
- oResValid  out  1  result valid.
- iResReady  in  1  readout accepts the result.
- oResult  out  RES_W  interval in fine bins.
- oTimeout  out  1  sticky; set on timeout, cleared by the next accepted iArm.
- oClamp  out  1  qualifies oResult; set when a negative interval was clamped to 0.

Behaviour:
- Reset (iRst=0 at a clock edge): state IDLE; all outputs 0; internal registers 0.
- States:
  - IDLE -> ARMED on iArm.
  - ARMED -> WAIT_STOP on iTdcValid; latch start coarse/fine, clear the timeout counter.
  - WAIT_STOP -> CALC on iTdcValid; latch stop coarse/fine.
  - WAIT_STOP -> IDLE when the counter reaches TIMEOUT_CYC-1 with no stop; set oTimeout.
  - CALC -> DONE after 1 cycle.
  - DONE -> IDLE on oResValid && iResReady.
- Arithmetic:
  - dc = (stop_coarse - start_coarse) mod 2^COARSE_W.
  - r = dc*BINS_PER_CLK + start_fine - stop_fine, computed signed at RES_W+2 bits.
  - If r < 0: oResult=0, oClamp=1. Otherwise oResult=r[RES_W-1:0], oClamp=0.
  - If r ≥ 2^RES_W: saturate to all-ones and set oClamp=1.
- Latency: stop strobe at edge N gives oResValid high after edge N+2.
- Handshake:
  - oResult and oClamp are stable while oResValid=1 and iResReady=0.
  - oResValid stays high until accepted; accept and drop happen on the same edge.
- Boundaries:
  - iTdcValid in IDLE, CALC or DONE is ignored. No queuing; hits during backpressure are lost.
  - iArm outside IDLE is ignored.
  - iAbort has priority over every transition, including a same-cycle stop strobe or accept. oResValid drops the next cycle.
  - Timeout and stop in the same cycle: the stop wins and no timeout is flagged.
  - Coarse wrap: handled by the modulo subtraction. Intervals ≥ 2^COARSE_W clocks alias; the timeout bounds this when TIMEOUT_CYC < 2^COARSE_W.
  - Reset mid-measurement: immediate IDLE. Results and the oTimeout flag are discarded.

Optional Feature:
- Macro: TDC_MEAS_AUTO_REARM_EN.
- Defined: DONE -> ARMED on accept, and timeout -> ARMED. The controller keeps measuring until iAbort. iArm is still required once from IDLE.
- Undefined: DONE and timeout return to IDLE; every measurement needs an iArm.

Decomposition:
- Shared package tdc_pkg:
  - State encoding (IDLE, ARMED, WAIT_STOP, CALC, DONE).
  - Default widths COARSE_W, FINE_W, BINS_PER_CLK.
  - Timestamp struct type {coarse, fine}.
- One sub-module: tdc_interval_calc. Combinational wrap subtract, multiply, fine correction and clamp; the controller registers its output in CALC.

Test Plan:
- Arm; start (coarse 5, fine 80); stop (coarse 30, fine 20) -> oResult=3060, oClamp=0, oResValid exactly 2 cycles after the stop strobe.
- Wrap: start (1020, 10); stop (3, 5) -> dc=7, oResult=845.
- Clamp: start (100, 10); stop (100, 40) -> oResult=0, oClamp=1.
- Timeout: arm, start, no stop for 1023 cycles -> oTimeout=1, state IDLE, no oResValid. The next iArm clears oTimeout.
- Backpressure: hold iResReady=0 for 20 cycles while 5 extra hits arrive -> oResult unchanged, hits ignored. Raise iResReady -> one transfer, then IDLE (or ARMED with TDC_MEAS_AUTO_REARM_EN).
- Disruption: assert iRst=0 in WAIT_STOP -> all outputs 0 next edge. Separately, assert iAbort in the same cycle as the stop strobe -> IDLE, no result.

Source files
------------

// File: rtl/tdc_pkg.sv
// tdc_pkg: types and default dimensions shared by the TDC measurement sequencer.
//   - tdc_state_e : sequencer state encoding
//   - tdc_ts_t    : timestamp {coarse, fine} at the default widths
//   - TDC_*       : default widths and timing constants for the TDC core
package tdc_pkg;

  localparam int unsigned TDC_COARSE_W     = 10;
  localparam int unsigned TDC_FINE_W       = 7;
  localparam int unsigned TDC_BINS_PER_CLK = 120;
  localparam int unsigned TDC_TIMEOUT_CYC  = 1023;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StWaitStop,
    StCalc,
    StDone
  } tdc_state_e;

  typedef struct packed {
    logic [TDC_COARSE_W-1:0] coarse;
    logic [TDC_FINE_W-1:0]   fine;
  } tdc_ts_t;

endpackage

// File: rtl/tdc_interval_calc.sv
// tdc_interval_calc: combinational start/stop interval in fine bins.
//   The coarse difference wraps modulo 2^COARSE_W. The result is clamped to 0
//   when negative and saturated to all-ones when it does not fit in RES_W bits;
//   o_clamp flags either case.
// Ports:
//   i_start_coarse, i_start_fine : start timestamp
//   i_stop_coarse,  i_stop_fine  : stop timestamp
//   o_result                     : interval in fine bins
//   o_clamp                      : result was clamped or saturated
module tdc_interval_calc #(
  parameter int unsigned COARSE_W     = tdc_pkg::TDC_COARSE_W,
  parameter int unsigned FINE_W       = tdc_pkg::TDC_FINE_W,
  parameter int unsigned BINS_PER_CLK = tdc_pkg::TDC_BINS_PER_CLK,
  parameter int unsigned RES_W        = COARSE_W + FINE_W
) (
  input  logic [COARSE_W-1:0] i_start_coarse,
  input  logic [FINE_W-1:0]   i_start_fine,
  input  logic [COARSE_W-1:0] i_stop_coarse,
  input  logic [FINE_W-1:0]   i_stop_fine,
  output logic [RES_W-1:0]    o_result,
  output logic                o_clamp
);

  // Two guard bits: one for the sign, one for overflow past RES_W.
  localparam int unsigned CALC_W = RES_W + 2;

  logic [COARSE_W-1:0] w_dc;
  logic [CALC_W-1:0]   w_r;

  always_comb begin
    // Unsigned subtraction at COARSE_W bits is the modulo wrap.
    w_dc = i_stop_coarse - i_start_coarse;
    // Two's-complement arithmetic; the MSB of w_r is the sign.
    w_r  = CALC_W'(w_dc) * CALC_W'(BINS_PER_CLK)
         + CALC_W'(i_start_fine) - CALC_W'(i_stop_fine);

    o_result = w_r[RES_W-1:0];
    o_clamp  = 1'b0;
    if (w_r[CALC_W-1]) begin
      o_result = '0;
      o_clamp  = 1'b1;
    end else if (w_r[CALC_W-2:RES_W] != '0) begin
      o_result = '1;
      o_clamp  = 1'b1;
    end
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: measurement sequencer for the TDC core.
//   Arms on iArm, takes the first two timestamps after arming as start and stop,
//   computes the interval in fine bins and presents it on a valid/ready
//   handshake. A stop that does not arrive within TIMEOUT_CYC cycles ends the
//   measurement with the sticky oTimeout flag. iAbort returns to IDLE from any
//   state and takes priority over every other transition.
// Build option:
//   TDC_MEAS_AUTO_REARM_EN - when defined, an accepted result and a timeout
//   both return to ARMED instead of IDLE, so measuring continues until iAbort.
// Ports:
//   iClk, iRst                    : clock, synchronous active-low reset
//   iArm, iAbort                  : start (from IDLE) / abort (from any state)
//   iTdcValid, iTdcCoarse, iTdcFine : timestamp strobe from the TDC core
//   oArmed, oBusy                 : state indicators
//   oResValid, iResReady          : result handshake
//   oResult, oClamp               : interval in bins and its clamp qualifier
//   oTimeout                      : sticky timeout flag
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int unsigned COARSE_W     = TDC_COARSE_W,
  parameter int unsigned FINE_W       = TDC_FINE_W,
  parameter int unsigned BINS_PER_CLK = TDC_BINS_PER_CLK,
  parameter int unsigned TIMEOUT_CYC  = TDC_TIMEOUT_CYC,
  parameter int unsigned RES_W        = COARSE_W + FINE_W
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iArm,
  input  logic                iAbort,
  input  logic                iTdcValid,
  input  logic [COARSE_W-1:0] iTdcCoarse,
  input  logic [FINE_W-1:0]   iTdcFine,
  output logic                oArmed,
  output logic                oBusy,
  output logic                oResValid,
  input  logic                iResReady,
  output logic [RES_W-1:0]    oResult,
  output logic                oTimeout,
  output logic                oClamp
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

`ifdef TDC_MEAS_AUTO_REARM_EN
  localparam tdc_state_e END_ST = StArmed;
`else
  localparam tdc_state_e END_ST = StIdle;
`endif

  typedef struct packed {
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
  } ts_t;

  tdc_state_e       r_state, w_next_state;
  ts_t              r_start, r_stop;
  logic [CNT_W-1:0] r_cnt;
  logic [RES_W-1:0] r_result;
  logic             r_clamp, r_timeout;

  logic             w_ld_start, w_ld_stop, w_ld_res, w_arm_acc, w_timeout;
  logic [RES_W-1:0] w_calc_result;
  logic             w_calc_clamp;

  tdc_interval_calc #(
    .COARSE_W     (COARSE_W),
    .FINE_W       (FINE_W),
    .BINS_PER_CLK (BINS_PER_CLK),
    .RES_W        (RES_W)
  ) u_calc (
    .i_start_coarse (r_start.coarse),
    .i_start_fine   (r_start.fine),
    .i_stop_coarse  (r_stop.coarse),
    .i_stop_fine    (r_stop.fine),
    .o_result       (w_calc_result),
    .o_clamp        (w_calc_clamp)
  );

  always_comb begin
    w_next_state = r_state;
    w_ld_start   = 1'b0;
    w_ld_stop    = 1'b0;
    w_ld_res     = 1'b0;
    w_arm_acc    = 1'b0;
    w_timeout    = 1'b0;
    if (iAbort) begin
      w_next_state = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (iArm) begin
            w_next_state = StArmed;
            w_arm_acc    = 1'b1;
          end
        end
        StArmed: begin
          if (iTdcValid) begin
            w_next_state = StWaitStop;
            w_ld_start   = 1'b1;
          end
        end
        StWaitStop: begin
          // A stop in the final cycle still wins over the timeout.
          if (iTdcValid) begin
            w_next_state = StCalc;
            w_ld_stop    = 1'b1;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            w_next_state = END_ST;
            w_timeout    = 1'b1;
          end
        end
        StCalc: begin
          w_next_state = StDone;
          w_ld_res     = 1'b1;
        end
        StDone: begin
          if (iResReady) begin
            w_next_state = END_ST;
          end
        end
        default: w_next_state = StIdle;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_state   <= StIdle;
      r_start   <= '0;
      r_stop    <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_clamp   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_ld_start) begin
        r_start <= '{coarse: iTdcCoarse, fine: iTdcFine};
        r_cnt   <= '0;
      end else if (r_state == StWaitStop) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_ld_stop) begin
        r_stop <= '{coarse: iTdcCoarse, fine: iTdcFine};
      end
      // Result only loads in CALC, so it holds steady through backpressure.
      if (w_ld_res) begin
        r_result <= w_calc_result;
        r_clamp  <= w_calc_clamp;
      end
      if (w_arm_acc) begin
        r_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    oArmed    = (r_state == StArmed);
    oBusy     = (r_state != StIdle);
    oResValid = (r_state == StDone);
    oResult   = r_result;
    oClamp    = r_clamp;
    oTimeout  = r_timeout;
  end

endmodule
